// File: rtl/code_emitter.sv
// code_emitter: descrambles a 56-bit code word into eight 7-bit slot characters and emits them in stride order
module code_emitter #(
    parameter int STRIDE    = 5,
    parameter int START_IDX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [55:0] code_in,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [6:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_slot,
    output logic        out_last
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
    localparam logic [2:0] START = 3'(START_IDX);
    localparam logic [2:0] STEP  = 3'(STRIDE);
    state_t      state, state_nx;
    logic [6:0]  slots [8];
    logic [2:0]  idx, cnt;
    logic [55:0] m;
    logic        fire;
    assign m    = {code_in[13:0], code_in[45:26], code_in[25:14], code_in[55:46]};
    assign fire = state == SEND && out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= START;
            cnt   <= '0;
            for (int i = 0; i < 8; i++) slots[i] <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                slots[0] <= m[55:49];
                slots[5] <= m[48:42];
                slots[6] <= m[41:35];
                slots[2] <= m[34:28];
                slots[4] <= m[27:21];
                slots[3] <= m[20:14];
                slots[7] <= m[13:7];
                slots[1] <= m[6:0];
            end
            if (state == LOAD) begin
                idx <= START;
                cnt <= '0;
            end else if (fire) begin
                idx <= idx + STEP;
                cnt <= cnt + 3'd1;
            end
        end
    end
    always_comb begin
        state_nx  = state == IDLE ? (start ? LOAD : IDLE) :
                    state == LOAD ? SEND :
                    state == SEND ? (fire && cnt == 3'd7 ? DONE : SEND) : IDLE;
        busy      = state != IDLE;
        done      = state == DONE;
        out_valid = state == SEND;
        out_data  = state == SEND ? slots[idx] : '0;
        out_slot  = idx;
        out_last  = state == SEND && cnt == 3'd7;
    end
endmodule

// File: tb/tb_code_emitter.sv
// tb_code_emitter: randomized handshake bench with a forward-scramble reference model
module tb_code_emitter;
    localparam int STRIDE    = 5;
    localparam int START_IDX = 0;
    logic        clk = 1'b0;
    logic        rst, start, out_ready, out_valid, busy, done, out_last;
    logic [55:0] code_in;
    logic [6:0]  out_data;
    logic [2:0]  out_slot;
    int          checks = 0, errors = 0;
    logic [6:0]  rx [8];
    int          chunk [8] = '{0, 5, 6, 2, 4, 3, 7, 1};
    code_emitter #(.STRIDE(STRIDE), .START_IDX(START_IDX)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .start(start), .busy(busy), .done(done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_slot(out_slot), .out_last(out_last)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int ord(input int c);
        return (START_IDX + c * STRIDE) % 8;
    endfunction
    function automatic logic [6:0] ref_char(input logic [55:0] k, input int slot);
        logic [55:0] mm;
        mm = {k[13:0], k[45:26], k[25:14], k[55:46]};
        for (int j = 0; j < 8; j++)
            if (chunk[j] == slot) return mm[55 - 7 * j -: 7];
        return '0;
    endfunction
    function automatic logic [55:0] reassemble();
        logic [55:0] mm;
        for (int j = 0; j < 8; j++) mm[55 - 7 * j -: 7] = rx[chunk[j]];
        return {mm[9:0], mm[41:22], mm[21:10], mm[55:42]};
    endfunction
    task automatic run(input logic [55:0] k, input int pct, input logic [55:0] alt, input int abort_at);
        int acc, first_v;
        logic fin, stall, rdy, pl;
        logic [6:0] pd;
        logic [2:0] ps;
        acc = 0; first_v = 0; fin = 0; stall = 0; pd = '0; ps = '0; pl = 0;
        for (int i = 0; i < 8; i++) rx[i] = '0;
        @(negedge clk);
        code_in = k;
        start = 1'b1;
        for (int n = 1; n < 300 && !fin; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (alt != k && n == 4) begin
                start = 1'b1;
                code_in = alt;
            end
            if (abort_at > 0 && acc == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                repeat (3) begin
                    @(negedge clk);
                    check("abort_no_done", done, 0);
                    check("abort_idle", out_valid, 0);
                end
                return;
            end
            if (n == 1) begin
                check("load_busy", busy, 1);
                check("load_valid", out_valid, 0);
            end
            if (out_valid && first_v == 0) first_v = n;
            if (stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, pd);
                check("stall_slot", out_slot, ps);
                check("stall_last", out_last, pl);
            end
            if (done) begin
                check("done_count", acc, 8);
                check("done_busy", busy, 1);
                check("done_valid", out_valid, 0);
                if (pct == 100) begin
                    check("first_valid_lat", first_v, 2);
                    check("done_lat", n, 10);
                end
                @(negedge clk);
                check("post_done", done, 0);
                check("post_busy", busy, 0);
                fin = 1;
            end else begin
                rdy = ($urandom_range(99) < pct);
                if (out_valid) begin
                    check("slot", out_slot, ord(acc));
                    check("data", out_data, ref_char(k, ord(acc)));
                    check("last", out_last, acc == 7);
                    check("send_busy", busy, 1);
                    if (rdy) begin
                        rx[out_slot] = out_data;
                        acc++;
                    end
                    stall = !rdy;
                    pd = out_data; ps = out_slot; pl = out_last;
                end else stall = 0;
                out_ready = rdy;
            end
        end
        if (!fin) check("timeout", 0, 1);
        check("round_trip", reassemble(), k);
    endtask
    initial begin
        logic [55:0] k, k2;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; code_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_slot", out_slot, START_IDX);
        rst = 1'b0;
        run(56'h0, 100, 56'h0, 0);
        for (int i = 0; i < 8; i++) check("zero_char", rx[i], 0);
        run(56'h1, 100, 56'h1, 0);
        check("bit0_s5", rx[5], 7'h01);
        check("bit0_s0", rx[0], 7'h00);
        run(56'h1 << 55, 100, 56'h1 << 55, 0);
        check("bit55_s7", rx[7], 7'h04);
        check("bit55_s5", rx[5], 7'h00);
        run(56'h1 << 26, 100, 56'h1 << 26, 0);
        check("bit26_s4", rx[4], 7'h02);
        check("bit26_s2", rx[2], 7'h00);
        run(56'd3008192072309708, 100, 56'd3008192072309708, 0);
        for (int r = 0; r < 1000; r++) begin
            k = 56'({$urandom, $urandom});
            run(k, 100, k, 0);
        end
        run(56'd3008192072309708, 40, 56'd3008192072309708, 0);
        for (int r = 0; r < 20; r++) begin
            k = 56'({$urandom, $urandom});
            run(k, 40, k, 0);
        end
        k = 56'({$urandom, $urandom});
        k2 = ~k;
        run(k, 100, k2, 0);
        run(k, 60, k2, 0);
        run(k, 100, k, 3);
        run(k2, 100, k2, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
